sp_head_shifter: RTL and testbench

Drives one print line into the print-head serial interface. It sequences the SP data serializer stage with a one-cycle start pulse, then one request pulse per bit. For each bit it captures the 16-bit parallel word, one bit per chip/phase lane, and presents it on 16 head data lines with a divided shift clock. It ends the line with a latch pulse and sits directly downstream of the SP data controller.

---
 rtl/sp_head_shifter_pkg.sv | 24 ++
 rtl/sp_head_shifter_if.sv | 22 ++
 rtl/sp_head_shifter_phase_timer.sv | 28 ++
 rtl/sp_head_shifter.sv | 159 +++++++++++++++
 tb/tb_sp_head_shifter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_head_shifter_pkg.sv
// Shared types and default constants for the print-head line shifter.
package sp_head_pkg;

  localparam int SP_HEAD_CLK_DIV = 4;
  localparam int SP_HEAD_BIT_CNT = 16;
  localparam int SP_HEAD_LATCH_W = 4;
  localparam int SP_HEAD_LANES   = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CAP,
    LOW,
    HIGH,
    LATCH,
    DONE
  } sp_head_state_t;

  // Counter width for a count of n values; never narrower than one bit.
  function automatic int sp_head_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sp_head_shifter_if.sv
// Serializer handshake plus head serial bus between the shifter and its neighbours.
interface sp_head_shifter_if;
  import sp_head_pkg::*;

  logic                     SPdata_start;
  logic                     SPdata_req;
  logic [SP_HEAD_LANES-1:0] SPdata;
  logic                     head_sclk;
  logic [SP_HEAD_LANES-1:0] head_sdata;
  logic                     head_latch;

  modport master (
    output SPdata_start, SPdata_req, head_sclk, head_sdata, head_latch,
    input  SPdata
  );

  modport slave (
    input  SPdata_start, SPdata_req, head_sclk, head_sdata, head_latch,
    output SPdata
  );

endinterface

// File: rtl/sp_head_shifter_phase_timer.sv
// Loadable down-counter with terminal-count and one-before-terminal flags.
module sp_head_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         near_tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc      = (cnt == '0);
  assign near_tc = (cnt == W'(1));

endmodule

// File: rtl/sp_head_shifter.sv
// Shifts one print line from the SP serializers into the head; optional abort input
// is built in when SP_HEAD_ABORT_EN is defined.
module sp_head_shifter
  import sp_head_pkg::*;
#(
  parameter int CLK_DIV = SP_HEAD_CLK_DIV,
  parameter int BIT_CNT = SP_HEAD_BIT_CNT,
  parameter int LATCH_W = SP_HEAD_LATCH_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                line_start,
`ifdef SP_HEAD_ABORT_EN
  input  logic                abort,
`endif
  output logic                busy,
  output logic                line_done,
  sp_head_shifter_if.master   sp
);

  // state | meaning
  // IDLE  | waiting for line_start
  // START | SPdata_start pulse, bit counter cleared
  // CAP   | head_sdata captures SPdata at end of cycle
  // LOW   | CLK_DIV cycles with head_sclk low
  // HIGH  | CLK_DIV cycles with head_sclk high; req or go to LATCH at the end
  // LATCH | LATCH_W cycles of head_latch
  // DONE  | line_done pulse

  localparam int PH_MAX = (CLK_DIV > LATCH_W) ? CLK_DIV : LATCH_W;
  localparam int PH_W   = sp_head_cnt_w(PH_MAX);
  localparam int BC_W   = $clog2(BIT_CNT);

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(BIT_CNT - 1);
  localparam logic [PH_W-1:0] DIV_LD   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] LAT_LD   = PH_W'(LATCH_W - 1);

  sp_head_state_t  state;
  logic [BC_W-1:0] bit_cnt;
  logic            last_bit;
  logic            tc;
  logic            near_tc;
  logic            timer_load;
  logic [PH_W-1:0] timer_val;
  logic            req_next;
  logic            abort_hit;

`ifdef SP_HEAD_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_bit = (bit_cnt == BIT_LAST);

  // The timer reloads on every state entry; outside the timed states it is held loaded.
  always_comb begin
    timer_load = 1'b1;
    timer_val  = DIV_LD;
    case (state)
      LOW:     timer_load = tc;
      HIGH: begin
        timer_load = tc;
        if (last_bit) timer_val = LAT_LD;
      end
      LATCH:   timer_load = tc;
      default: timer_load = 1'b1;
    endcase
  end

  // req is registered, so it is raised one cycle ahead of the last HIGH cycle.
  assign req_next = !last_bit &&
                    (((state == LOW) && tc && (CLK_DIV == 1)) ||
                     ((state == HIGH) && near_tc));

  sp_head_phase_timer #(.W(PH_W)) u_phase_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (tc),
    .near_tc  (near_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      busy            <= 1'b0;
      line_done       <= 1'b0;
      sp.SPdata_start <= 1'b0;
      sp.SPdata_req   <= 1'b0;
      sp.head_sclk    <= 1'b0;
      sp.head_sdata   <= '0;
      sp.head_latch   <= 1'b0;
    end else if (abort_hit) begin
      state           <= IDLE;
      busy            <= 1'b0;
      line_done       <= 1'b0;
      sp.SPdata_start <= 1'b0;
      sp.SPdata_req   <= 1'b0;
      sp.head_sclk    <= 1'b0;
      sp.head_sdata   <= '0;
      sp.head_latch   <= 1'b0;
    end else begin
      sp.SPdata_start <= 1'b0;
      sp.SPdata_req   <= req_next;
      line_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (line_start) begin
            state           <= START;
            busy            <= 1'b1;
            sp.SPdata_start <= 1'b1;
          end
        end
        START: begin
          state   <= CAP;
          bit_cnt <= '0;
        end
        CAP: begin
          sp.head_sdata <= sp.SPdata;
          state         <= LOW;
        end
        LOW: begin
          if (tc) begin
            state        <= HIGH;
            sp.head_sclk <= 1'b1;
          end
        end
        HIGH: begin
          if (tc) begin
            sp.head_sclk <= 1'b0;
            if (last_bit) begin
              state         <= LATCH;
              sp.head_latch <= 1'b1;
            end else begin
              state   <= CAP;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        LATCH: begin
          if (tc) begin
            sp.head_latch <= 1'b0;
            state         <= DONE;
            line_done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_head_shifter.sv
// Scoreboard bench: stimulus pushes expected head words and line lengths, monitors pop and compare.
module tb_sp_head_shifter;
  import sp_head_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic line_start = 1'b0;
  logic line_start2 = 1'b0;
  logic busy, line_done, busy2, line_done2;
`ifdef SP_HEAD_ABORT_EN
  logic abort = 1'b0;
  logic abort2 = 1'b0;
`endif

  sp_head_shifter_if sp1();
  sp_head_shifter_if sp2();

  sp_head_shifter u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .line_start (line_start),
`ifdef SP_HEAD_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .line_done  (line_done),
    .sp         (sp1)
  );

  sp_head_shifter #(.CLK_DIV(1), .BIT_CNT(2), .LATCH_W(1)) u_dut2 (
    .clk        (clk),
    .rstn       (rstn),
    .line_start (line_start2),
`ifdef SP_HEAD_ABORT_EN
    .abort      (abort2),
`endif
    .busy       (busy2),
    .line_done  (line_done2),
    .sp         (sp2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] exp_word[$];
  int          exp_len[$];
  logic [15:0] exp2_word[$];
  int          exp2_len[$];

  int          next_mode = 0;
  logic [15:0] next_const = 16'h0000;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [15:0] word_of(input int mode, input logic [15:0] c, input int k);
    if (mode == 0) return 16'h0001 << k;
    return c;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Upstream serializer model for the default-parameter instance.
  initial begin
    int          u_mode;
    logic [15:0] u_const;
    int          u_k;
    u_mode = 0; u_const = '0; u_k = 0;
    sp1.SPdata = '0;
    forever begin
      @(negedge clk);
      if (sp1.SPdata_start) begin
        u_mode = next_mode; u_const = next_const; u_k = 0;
        sp1.SPdata = word_of(u_mode, u_const, 0);
      end else if (sp1.SPdata_req) begin
        u_k++;
        sp1.SPdata = word_of(u_mode, u_const, u_k);
      end
    end
  end

  initial begin
    sp2.SPdata = '0;
    forever begin
      @(negedge clk);
      if (sp2.SPdata_start) sp2.SPdata = 16'hA5A5;
      else if (sp2.SPdata_req) sp2.SPdata = 16'h5A5A;
    end
  end

  // Monitor for the default instance.
  initial begin
    logic        prev_sclk;
    logic [15:0] cur_word;
    int st_cyc, n_req, n_rise, n_lat, len;
    prev_sclk = 0; cur_word = '0; st_cyc = 0; n_req = 0; n_rise = 0; n_lat = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_sclk = 0;
        continue;
      end
      if (sp1.SPdata_start) begin
        st_cyc = cyc; n_req = 0; n_rise = 0; n_lat = 0;
        check("start_req_exclusive", {31'd0, sp1.SPdata_req}, 32'd0);
      end
      if (sp1.SPdata_req) n_req++;
      if (sp1.head_latch) n_lat++;
      if (sp1.head_sclk && !prev_sclk) begin
        n_rise++;
        if (exp_word.size() == 0) fail_now("sclk_rise_unexpected");
        else begin
          cur_word = exp_word.pop_front();
          check("sdata_at_rise", {16'd0, sp1.head_sdata}, {16'd0, cur_word});
        end
      end
      if (!sp1.head_sclk && prev_sclk)
        check("sdata_stable_high", {16'd0, sp1.head_sdata}, {16'd0, cur_word});
      if (line_done) begin
        if (exp_len.size() == 0) fail_now("line_done_unexpected");
        else begin
          len = exp_len.pop_front();
          check("line_len", cyc - st_cyc + 1, len);
          check("req_count", n_req, 15);
          check("rise_count", n_rise, 16);
          check("latch_width", n_lat, 4);
        end
      end
      prev_sclk = sp1.head_sclk;
    end
  end

  // Monitor for the CLK_DIV=1, BIT_CNT=2, LATCH_W=1 instance.
  initial begin
    logic prev_sclk;
    int   st_cyc, n_req, n_high, len;
    prev_sclk = 0; st_cyc = 0; n_req = 0; n_high = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_sclk = 0;
        continue;
      end
      if (sp2.SPdata_start) begin st_cyc = cyc; n_req = 0; end
      if (sp2.SPdata_req) n_req++;
      if (sp2.head_sclk) n_high++;
      if (sp2.head_sclk && !prev_sclk) begin
        n_high = 1;
        if (exp2_word.size() == 0) fail_now("small_rise_unexpected");
        else check("small_sdata_at_rise", {16'd0, sp2.head_sdata}, {16'd0, exp2_word.pop_front()});
      end
      if (!sp2.head_sclk && prev_sclk) check("small_sclk_high_width", n_high, 1);
      if (line_done2) begin
        if (exp2_len.size() == 0) fail_now("small_done_unexpected");
        else begin
          len = exp2_len.pop_front();
          check("small_line_len", cyc - st_cyc + 1, len);
          check("small_req_count", n_req, 1);
        end
      end
      prev_sclk = sp2.head_sclk;
    end
  end

  // Caller is at a negedge; line_start is high for exactly one cycle.
  task automatic start_line(input int mode, input logic [15:0] c, input int n_words, input bit push_len);
    for (int k = 0; k < n_words; k++) exp_word.push_back(word_of(mode, c, k));
    if (push_len) exp_len.push_back(150);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!sp1.SPdata_start && n < 400) begin @(negedge clk); n++; end
    if (!sp1.SPdata_start) fail_now(nm);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!line_done && n < 400) begin @(negedge clk); n++; end
    if (!line_done) fail_now(nm);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_busy"},   {31'd0, busy}, 0);
    check({nm, "_done"},   {31'd0, line_done}, 0);
    check({nm, "_start"},  {31'd0, sp1.SPdata_start}, 0);
    check({nm, "_req"},    {31'd0, sp1.SPdata_req}, 0);
    check({nm, "_sclk"},   {31'd0, sp1.head_sclk}, 0);
    check({nm, "_sdata"},  {16'd0, sp1.head_sdata}, 0);
    check({nm, "_latch"},  {31'd0, sp1.head_latch}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Line A: walking-one pattern, with pulses inside the line that must be ignored.
    next_mode = 0;
    start_line(0, '0, 16, 1);
    wait_start("line_a_start");
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      line_start = (i == 10 || i == 50 || i == 149);
    end
    repeat (4) @(negedge clk);
    check("ignored_pulses_no_line", {31'd0, busy}, 0);

    // All-ones line followed back-to-back by an all-zeros line.
    next_mode = 1; next_const = 16'hFFFF;
    start_line(1, 16'hFFFF, 16, 1);
    wait_start("ones_start");
    @(negedge clk);
    next_const = 16'h0000;
    wait_done("ones_done");
    @(negedge clk);
    start_line(1, 16'h0000, 16, 1);
    check("b2b_start_after_one_idle", {31'd0, sp1.SPdata_start}, 1);
    wait_done("zeros_done");
    repeat (5) @(negedge clk);
    check("idle_hold_sdata", {16'd0, sp1.head_sdata}, 0);
    check("idle_busy", {31'd0, busy}, 0);

    // Reset during bit 7 high phase, then a full clean line.
    next_mode = 0;
    start_line(0, '0, 8, 0);
    wait_start("rst_line_start");
    repeat (70) @(negedge clk);
    check("pre_reset_sclk_high", {31'd0, sp1.head_sclk}, 1);
    #1 rstn = 1'b0;
    #1 check_idle_outputs("midline_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    start_line(0, '0, 16, 1);
    wait_done("post_reset_done");
    @(negedge clk);

`ifdef SP_HEAD_ABORT_EN
    begin
      int n;
      start_line(0, '0, 16, 0);
      n = 0;
      while (!sp1.head_latch && n < 400) begin @(negedge clk); n++; end
      if (!sp1.head_latch) fail_now("abort_latch_wait");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_latch", {31'd0, sp1.head_latch}, 0);
      check("abort_sdata", {16'd0, sp1.head_sdata}, 0);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      start_line(0, '0, 16, 1);
      abort = 1'b0;
      check("abort_with_start_in_idle", {31'd0, sp1.SPdata_start}, 1);
      wait_done("abort_then_line_done");
      @(negedge clk);
    end
`endif

    // Minimal-parameter instance.
    exp2_word.push_back(16'hA5A5);
    exp2_word.push_back(16'h5A5A);
    exp2_len.push_back(9);
    line_start2 = 1'b1;
    @(negedge clk);
    line_start2 = 1'b0;
    begin
      int n = 0;
      while (!line_done2 && n < 50) begin @(negedge clk); n++; end
      if (!line_done2) fail_now("small_done_wait");
    end
    repeat (5) @(negedge clk);

    check("word_queue_drained", exp_word.size(), 0);
    check("len_queue_drained", exp_len.size(), 0);
    check("small_word_queue_drained", exp2_word.size(), 0);
    check("small_len_queue_drained", exp2_len.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
